psubsb_seq: RTL

PSUBSB_SEQ -- requirements
Module: psubsb_seq

---
 rtl/psubsb_seq.sv | 106 ++++++++++
 1 files changed

// File: rtl/psubsb_seq.sv
// psubsb_seq: sequential packed saturating subtract of four signed 4-bit lanes.
// One lane is resolved per cycle (lane 0 first); done pulses once all four
// lanes have been written, and the results hold until the next accepted start.
module psubsb_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] A,
   input  logic [15:0] B,
   output logic        busy,
   output logic        done,
   output logic [15:0] Diff,
   output logic [3:0]  Sat
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_reg, state_next;
   logic [1:0]  lane_reg, lane_next;
   logic [15:0] a_reg, a_next;
   logic [15:0] b_reg, b_next;
   logic [15:0] diff_reg, diff_next;
   logic [3:0]  sat_reg, sat_next;

   // Saturated result and overflow flag of every lane, from the latched operands.
   logic [3:0][3:0] lane_res;
   logic [3:0]      lane_ovf;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [3:0] al, bl, raw;
         assign al  = a_reg[4*gi +: 4];
         assign bl  = b_reg[4*gi +: 4];
         assign raw = al - bl;
         // Overflow only possible when the operand signs differ.
         assign lane_ovf[gi] = (al[3] != bl[3]) && (raw[3] != al[3]);
         assign lane_res[gi] = lane_ovf[gi] ? (al[3] ? 4'b1000 : 4'b0111) : raw;
      end
   endgenerate

   // State and datapath registers, asynchronously cleared by rst_n.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
         lane_reg  <= 2'd0;
         a_reg     <= 16'h0000;
         b_reg     <= 16'h0000;
         diff_reg  <= 16'h0000;
         sat_reg   <= 4'h0;
      end else begin
         state_reg <= state_next;
         lane_reg  <= lane_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         diff_reg  <= diff_next;
         sat_reg   <= sat_next;
      end
   end

   // Next-state and datapath update: accept in IDLE, one lane per BUSY cycle.
   always_comb begin
      state_next = state_reg;
      lane_next  = lane_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      diff_next  = diff_reg;
      sat_next   = sat_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               a_next     = A;
               b_next     = B;
               diff_next  = 16'h0000;
               sat_next   = 4'h0;
               lane_next  = 2'd0;
               state_next = BUSY;
            end
         end
         BUSY: begin
            diff_next[{lane_reg, 2'b00} +: 4] = lane_res[lane_reg];
            sat_next[lane_reg]                = lane_ovf[lane_reg];
            lane_next                         = lane_reg + 2'd1;
            if (lane_reg == 2'd3) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign busy = (state_reg == BUSY);
   assign done = (state_reg == DONE);
   assign Diff = diff_reg;
   assign Sat  = sat_reg;

endmodule
